subckt_stim_gen: RTL

SUBCKT_STIM_GEN -- requirements
Module: subckt_stim_gen

---
 rtl/subckt_stim_gen.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/subckt_stim_gen.sv
// LFSR stimulus generator for a small subcircuit, with pipelined response capture and fire statistics.
// Define SUBCKT_STIM_MISR_EN to add a 16-bit response MISR on the signature port.
module subckt_stim_gen #(
    parameter int PIPE_LAT = 3,
    parameter int CNT_W    = 12
) (
    input  logic             I1470_clk,
    input  logic             I1477_rst,
    input  logic             start,
    input  logic [15:0]      seed,
    input  logic [CNT_W-1:0] num_vec,
    output logic [3:0]       stim_out,
    output logic             stim_valid,
    input  logic             resp_in,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] fire_cnt,
    output logic [CNT_W-1:0] first_fire_idx
`ifdef SUBCKT_STIM_MISR_EN
    ,
    output logic [15:0]      signature
`endif
);

    // state | meaning
    // IDLE  | waiting for start
    // LOAD  | seed LFSR, clear results (1 cycle)
    // DRIVE | one stimulus vector per cycle
    // DRAIN | PIPE_LAT cycles for in-flight responses
    // DONE  | one-cycle done pulse
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DRIVE,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
    localparam logic [CNT_W-1:0] ALL_ONES   = '1;
    localparam logic [2:0]       DRAIN_INIT = 3'(PIPE_LAT - 1);

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    state_t           r_state;
    state_t           w_next;
    logic [15:0]      r_lfsr;
    logic [CNT_W-1:0] r_vec_idx;
    logic [CNT_W-1:0] r_num_vec;
    logic [2:0]       r_drain_cnt;
    logic [PIPE_LAT-1:0] r_dl_valid;
    logic [CNT_W-1:0] r_dl_idx [PIPE_LAT];
    logic [CNT_W-1:0] r_fire_cnt;
    logic [CNT_W-1:0] r_first_fire_idx;
    logic             w_capture;
    logic             w_load;
    logic             w_clear;
    logic             w_drain_start;
    logic             w_sample;

    always_ff @(posedge I1470_clk or negedge I1477_rst) begin
        if (!I1477_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_capture     = 1'b0;
        w_load        = 1'b0;
        w_clear       = 1'b0;
        w_drain_start = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (num_vec != '0) begin
                        w_next    = S_LOAD;
                        w_capture = 1'b1;
                    end else begin
                        w_next  = S_DONE;
                        w_clear = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                w_load = 1'b1;
                w_next = S_DRIVE;
            end
            S_DRIVE: begin
                if (r_vec_idx == r_num_vec - ONE) begin
                    w_next        = S_DRAIN;
                    w_drain_start = 1'b1;
                end
            end
            S_DRAIN: begin
                if (r_drain_cnt == 3'd0) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign stim_valid = (r_state == S_DRIVE);
    assign stim_out   = stim_valid ? r_lfsr[3:0] : 4'h0;
    assign busy       = (r_state == S_LOAD) || (r_state == S_DRIVE) || (r_state == S_DRAIN);
    assign done       = (r_state == S_DONE);
    assign w_sample   = r_dl_valid[PIPE_LAT-1];

    always_ff @(posedge I1470_clk or negedge I1477_rst) begin
        if (!I1477_rst) begin
            r_lfsr      <= '0;
            r_vec_idx   <= '0;
            r_num_vec   <= '0;
            r_drain_cnt <= '0;
            r_dl_valid  <= '0;
            for (int i = 0; i < PIPE_LAT; i++) begin
                r_dl_idx[i] <= '0;
            end
        end else begin
            if (w_capture) begin
                r_num_vec <= num_vec;
            end
            // An all-zero seed would lock the LFSR, so it is replaced by 1.
            if (w_load) begin
                r_lfsr    <= (seed == 16'h0000) ? 16'h0001 : seed;
                r_vec_idx <= '0;
            end else if (r_state == S_DRIVE) begin
                r_lfsr    <= lfsr_step(r_lfsr);
                r_vec_idx <= r_vec_idx + ONE;
            end
            if (w_drain_start) begin
                r_drain_cnt <= DRAIN_INIT;
            end else if ((r_state == S_DRAIN) && (r_drain_cnt != 3'd0)) begin
                r_drain_cnt <= r_drain_cnt - 3'd1;
            end
            r_dl_valid[0] <= stim_valid;
            r_dl_idx[0]   <= r_vec_idx;
            for (int i = 1; i < PIPE_LAT; i++) begin
                r_dl_valid[i] <= r_dl_valid[i-1];
                r_dl_idx[i]   <= r_dl_idx[i-1];
            end
        end
    end

    always_ff @(posedge I1470_clk or negedge I1477_rst) begin
        if (!I1477_rst) begin
            r_fire_cnt       <= '0;
            r_first_fire_idx <= ALL_ONES;
        end else if (w_load || w_clear) begin
            r_fire_cnt       <= '0;
            r_first_fire_idx <= ALL_ONES;
        end else if (w_sample && resp_in) begin
            if (r_fire_cnt != ALL_ONES) begin
                r_fire_cnt <= r_fire_cnt + ONE;
            end
            // Vector indices never reach all-ones, so it doubles as "no fire yet".
            if (r_first_fire_idx == ALL_ONES) begin
                r_first_fire_idx <= r_dl_idx[PIPE_LAT-1];
            end
        end
    end

    assign fire_cnt       = r_fire_cnt;
    assign first_fire_idx = r_first_fire_idx;

`ifdef SUBCKT_STIM_MISR_EN
    logic [15:0] r_sig;

    always_ff @(posedge I1470_clk or negedge I1477_rst) begin
        if (!I1477_rst) begin
            r_sig <= '0;
        end else if (w_load || w_clear) begin
            r_sig <= '0;
        end else if (w_sample) begin
            r_sig <= lfsr_step(r_sig) ^ {15'b0, resp_in};
        end
    end

    assign signature = r_sig;
`endif

endmodule
